// File: rtl/comp_muldiv_pkg.sv
// comp_muldiv shared definitions: operation encodings and FSM states.
package comp_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/comp_muldiv_step.sv
// Shared WIDTH+1 bit adder/subtractor for the shift-add and trial-subtract steps.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] res,
    output logic           cout
);

    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   b_eff;

    // cout on subtract means a >= b (no borrow)
    assign b_eff = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub};
    assign res   = sum[WIDTH:0];
    assign cout  = sum[WIDTH+1];

endmodule

// File: rtl/comp_muldiv.sv
// Iterative signed/unsigned multiply/divide unit, one bit per cycle.
module comp_muldiv
    import comp_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic [1:0]         Op_in,
    input  logic [WIDTH-1:0]   Operand_a_in,
    input  logic [WIDTH-1:0]   Operand_b_in,
    output logic [2*WIDTH-1:0] Result_out,
    output logic               Ready,
    output logic               Busy,
    output logic               DivByZero
);

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sign_a_q, sign_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    logic               div_in, sgn_in, sa_in, sb_in, dbz_start;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               is_div;
    logic [WIDTH:0]     step_a, step_b, step_res;
    logic               step_cout;
    logic [2*WIDTH-1:0] calc_nxt, fix_val;
    logic [WIDTH-1:0]   quo, rem;
    logic               neg;

    assign div_in    = Op_in[1];
    assign sgn_in    = Op_in[0];
    assign sa_in     = sgn_in & Operand_a_in[WIDTH-1];
    assign sb_in     = sgn_in & Operand_b_in[WIDTH-1];
    assign mag_a     = sa_in ? -Operand_a_in : Operand_a_in;
    assign mag_b     = sb_in ? -Operand_b_in : Operand_b_in;
    assign dbz_start = div_in && (Operand_b_in == '0);

    // Divide works on {rem, quot}; multiply on {hi, multiplier}
    assign is_div = op_q[1];
    assign step_a = is_div ? acc_q[2*WIDTH-1:WIDTH-1]
                           : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign step_b = (is_div || acc_q[0]) ? {1'b0, opnd_q} : '0;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .a    (step_a),
        .b    (step_b),
        .sub  (is_div),
        .res  (step_res),
        .cout (step_cout)
    );

    always_comb begin
        calc_nxt = {step_res, acc_q[WIDTH-1:1]};
        if (is_div) begin
            if (step_cout)
                calc_nxt = {step_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                calc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    assign quo = acc_q[WIDTH-1:0];
    assign rem = acc_q[2*WIDTH-1:WIDTH];
    assign neg = sign_a_q ^ sign_b_q;

    always_comb begin
        fix_val = acc_q;
        case (op_q)
            OP_MULS: if (neg) fix_val = -acc_q;
            OP_DIVS: fix_val = {sign_a_q ? -rem : rem, neg ? -quo : quo};
            default: fix_val = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Run) state_nxt = dbz_start ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (!Run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Run) begin
                    op_q     <= Op_in;
                    sign_a_q <= sa_in;
                    sign_b_q <= sb_in;
                    if (dbz_start) begin
                        result_q <= {Operand_a_in, {WIDTH{1'b1}}};
                        dbz_q    <= 1'b1;
                    end else begin
                        dbz_q  <= 1'b0;
                        cnt_q  <= CNT_W'(WIDTH);
                        opnd_q <= div_in ? mag_b : mag_a;
                        acc_q  <= {{WIDTH{1'b0}}, div_in ? mag_a : mag_b};
                    end
                end
                CALC: begin
                    acc_q <= calc_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: result_q <= fix_val;
                default: ;
            endcase
        end
    end

    assign Result_out = result_q;
    assign Ready      = (state == DONE);
    assign Busy       = (state == CALC) || (state == FIX);
    assign DivByZero  = dbz_q;

endmodule
